// File: rtl/flag_unit.sv
// Status-flag register with a single-level shadow copy and a microcode branch
// condition evaluator. Flags are held as {C,Z,V,S}.
module flag_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_s,
  input  logic       shift_c,
  input  logic [3:0] data_in,
  input  logic [2:0] sst,
  input  logic       save,
  input  logic       restore,
  input  logic [2:0] cond,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_v,
  output logic       flag_s,
  output logic [3:0] flags_out,
  output logic       shadow_valid,
  output logic       cond_ok
);

  localparam int unsigned BitC = 3;
  localparam int unsigned BitZ = 2;
  localparam int unsigned BitV = 1;
  localparam int unsigned BitS = 0;

  logic [3:0] flags_q, flags_d;
  logic [3:0] shadow_q, shadow_d;
  logic       valid_q, valid_d;
  logic [3:0] sst_flags;
  logic       do_restore;

  // A restore only counts when there is a saved image to return to.
  assign do_restore = restore & valid_q;

  always_comb begin
    sst_flags = flags_q;
    unique case (sst)
      3'b001: sst_flags = {alu_c, alu_z, alu_v, alu_s};
      3'b010: begin
        sst_flags[BitZ] = alu_z;
        sst_flags[BitS] = alu_s;
      end
      3'b011: sst_flags[BitC] = 1'b0;
      3'b100: sst_flags[BitC] = 1'b1;
      3'b101: sst_flags = data_in;
      3'b110: sst_flags[BitC] = shift_c;
      3'b000, 3'b111: sst_flags = flags_q;
    endcase
  end

  always_comb begin
    flags_d  = do_restore ? shadow_q : sst_flags;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    // Save takes the pre-update flags; with a valid restore this forms a swap.
    if (save) begin
      shadow_d = flags_q;
      valid_d  = 1'b1;
    end else if (do_restore) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= 4'b0000;
      shadow_q <= 4'b0000;
      valid_q  <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    cond_ok = 1'b1;
    unique case (cond)
      3'b000: cond_ok = 1'b1;
      3'b001: cond_ok = flags_q[BitC];
      3'b010: cond_ok = ~flags_q[BitC];
      3'b011: cond_ok = flags_q[BitZ];
      3'b100: cond_ok = ~flags_q[BitZ];
      3'b101: cond_ok = flags_q[BitS];
      3'b110: cond_ok = flags_q[BitV];
      3'b111: cond_ok = flags_q[BitS] ^ flags_q[BitV];
    endcase
  end

  assign flag_c       = flags_q[BitC];
  assign flag_z       = flags_q[BitZ];
  assign flag_v       = flags_q[BitV];
  assign flag_s       = flags_q[BitS];
  assign flags_out    = flags_q;
  assign shadow_valid = valid_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed plus random bench for flag_unit against a behavioural flag model.
module tb_flag_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       alu_c = 1'b0, alu_z = 1'b0, alu_v = 1'b0, alu_s = 1'b0;
  logic       shift_c = 1'b0;
  logic [3:0] data_in = 4'b0;
  logic [2:0] sst = 3'b0;
  logic       save = 1'b0, restore = 1'b0;
  logic [2:0] cond = 3'b0;
  logic       flag_c, flag_z, flag_v, flag_s;
  logic [3:0] flags_out;
  logic       shadow_valid;
  logic       cond_ok;

  int checks = 0;
  int errors = 0;

  // Reference state: flags as separate named bits, shadow as a packed image.
  bit m_c, m_z, m_v, m_s;
  bit [3:0] m_shadow;
  bit m_valid;

  flag_unit dut (
    .clk         (clk),
    .reset       (reset),
    .alu_c       (alu_c),
    .alu_z       (alu_z),
    .alu_v       (alu_v),
    .alu_s       (alu_s),
    .shift_c     (shift_c),
    .data_in     (data_in),
    .sst         (sst),
    .save        (save),
    .restore     (restore),
    .cond        (cond),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .flag_v      (flag_v),
    .flag_s      (flag_s),
    .flags_out   (flags_out),
    .shadow_valid(shadow_valid),
    .cond_ok     (cond_ok)
  );

  always #20 clk = ~clk;

  function automatic bit [3:0] m_image();
    return {m_c, m_z, m_v, m_s};
  endfunction

  function automatic bit m_cond(input int sel);
    bit lt;
    lt = (m_s != m_v);
    if (sel == 0) return 1'b1;
    if (sel == 1) return m_c;
    if (sel == 2) return !m_c;
    if (sel == 3) return m_z;
    if (sel == 4) return !m_z;
    if (sel == 5) return m_s;
    if (sel == 6) return m_v;
    return lt;
  endfunction

  // Applies the inputs present at the clock edge to the model.
  task automatic m_update();
    bit [3:0] old_img;
    bit       restoring;
    old_img   = m_image();
    restoring = restore && m_valid;
    if (reset) begin
      {m_c, m_z, m_v, m_s} = 4'b0000;
      m_shadow = 4'b0000;
      m_valid  = 1'b0;
    end else begin
      if (restoring) {m_c, m_z, m_v, m_s} = m_shadow;
      else if (sst == 3'd1) {m_c, m_z, m_v, m_s} = {alu_c, alu_z, alu_v, alu_s};
      else if (sst == 3'd2) begin m_z = alu_z; m_s = alu_s; end
      else if (sst == 3'd3) m_c = 1'b0;
      else if (sst == 3'd4) m_c = 1'b1;
      else if (sst == 3'd5) {m_c, m_z, m_v, m_s} = data_in;
      else if (sst == 3'd6) m_c = shift_c;
      if (save) begin
        m_shadow = old_img;
        m_valid  = 1'b1;
      end else if (restoring) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_state(input string tag);
    logic [3:0] exp_img;
    exp_img = m_image();
    checks++;
    assert (flags_out === exp_img) else begin
      errors++;
      $error("FAIL %s flags_out: got %b expected %b", tag, flags_out, exp_img);
    end
    checks++;
    assert ({flag_c, flag_z, flag_v, flag_s} === exp_img) else begin
      errors++;
      $error("FAIL %s flag_*: got %b expected %b", tag, {flag_c, flag_z, flag_v, flag_s},
             exp_img);
    end
    checks++;
    assert (shadow_valid === m_valid) else begin
      errors++;
      $error("FAIL %s shadow_valid: got %b expected %b", tag, shadow_valid, m_valid);
    end
    for (int i = 0; i < 8; i++) begin
      cond = 3'(i);
      #1;
      checks++;
      assert (cond_ok === m_cond(i)) else begin
        errors++;
        $error("FAIL %s cond_ok[cond=%0d]: got %b expected %b", tag, i, cond_ok, m_cond(i));
      end
    end
  endtask

  task automatic check_const(input string tag, input logic [3:0] exp_img, input logic exp_v);
    checks++;
    assert (flags_out === exp_img && shadow_valid === exp_v) else begin
      errors++;
      $error("FAIL %s const: got flags %b valid %b expected flags %b valid %b", tag, flags_out,
             shadow_valid, exp_img, exp_v);
    end
  endtask

  task automatic step(input logic rst, input logic sv, input logic rs, input logic [2:0] s,
                      input logic [3:0] alu, input logic sc, input logic [3:0] din,
                      input string tag);
    reset   = rst;
    save    = sv;
    restore = rs;
    sst     = s;
    {alu_c, alu_z, alu_v, alu_s} = alu;
    shift_c = sc;
    data_in = din;
    @(posedge clk);
    m_update();
    #1;
    check_state(tag);
  endtask

  initial begin
    m_c = 0; m_z = 0; m_v = 0; m_s = 0; m_shadow = 0; m_valid = 0;
    step(1, 0, 0, 3'd0, 4'h0, 0, 4'h0, "reset");
    check_const("reset", 4'b0000, 1'b0);

    step(0, 0, 0, 3'd1, 4'b1011, 0, 4'h0, "alu_load");
    check_const("alu_load", 4'b1011, 1'b0);
    step(0, 0, 0, 3'd2, 4'b0000, 0, 4'h0, "zs_load");
    check_const("zs_load", 4'b1010, 1'b0);
    step(0, 0, 0, 3'd3, 4'b1111, 1, 4'hF, "clr_c");
    check_const("clr_c", 4'b0010, 1'b0);
    step(0, 0, 0, 3'd4, 4'b0000, 0, 4'h0, "set_c");
    check_const("set_c", 4'b1010, 1'b0);
    step(0, 0, 0, 3'd6, 4'b1111, 0, 4'hF, "shift_c");
    check_const("shift_c", 4'b0010, 1'b0);
    step(0, 0, 0, 3'd7, 4'b1111, 1, 4'hF, "hold7");
    step(0, 0, 0, 3'd0, 4'b1111, 1, 4'hF, "hold0");

    step(0, 0, 0, 3'd5, 4'h0, 0, 4'b1100, "popf");
    step(0, 1, 0, 3'd5, 4'h0, 0, 4'b0011, "save_popf");
    check_const("save_popf", 4'b0011, 1'b1);
    step(0, 0, 1, 3'd1, 4'b1111, 0, 4'h0, "restore");
    check_const("restore", 4'b1100, 1'b0);
    step(0, 0, 1, 3'd4, 4'h0, 0, 4'h0, "restore_empty");
    check_const("restore_empty", 4'b1100, 1'b0);

    step(0, 0, 0, 3'd5, 4'h0, 0, 4'b1010, "pre_swap1");
    step(0, 1, 0, 3'd5, 4'h0, 0, 4'b0101, "pre_swap2");
    step(0, 1, 1, 3'd1, 4'b1111, 0, 4'h0, "swap");
    check_const("swap", 4'b1010, 1'b1);
    step(0, 0, 1, 3'd0, 4'h0, 0, 4'h0, "post_swap");
    check_const("post_swap", 4'b0101, 1'b0);

    step(0, 0, 0, 3'd1, 4'b1111, 0, 4'h0, "pre_reset");
    step(1, 1, 1, 3'd1, 4'b1111, 1, 4'hF, "reset_mid");
    check_const("reset_mid", 4'b0000, 1'b0);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0), 3'($urandom), 4'($urandom), 1'($urandom),
           4'($urandom), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
